// File: rtl/link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : link_pkg
// Brief    : Shared types and constants for the link-port serial engine.
// Revision : 1.0 - initial release
// ============================================================================
package link_pkg;

  // Transfer sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INT_LO   = 3'd1,
    ST_INT_HI   = 3'd2,
    ST_EXT_WAIT = 3'd3,
    ST_DONE     = 3'd4
  } link_state_e;

  // SC register bit positions
  localparam int SC_BIT_START = 7;
  localparam int SC_BIT_FAST  = 1;
  localparam int SC_BIT_INT   = 0;

  // Divisors for an 8.388 MHz system clock
  localparam int DIV_NORMAL_8M = 511;
  localparam int DIV_FAST_8M   = 15;

endpackage
`default_nettype wire

// File: rtl/link_in_sync.sv
`default_nettype none
// ============================================================================
// Module   : link_in_sync
// Brief    : Two-flop synchroniser for an asynchronous link pin with
//            single-cycle rise/fall pulses on the synchronised level.
//            All flops reset to 1 (idle-high pin) so reset never fakes an edge.
// Revision : 1.0 - initial release
// ============================================================================
module link_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic hist_q, hist_d;

  // Next-state: shift the pin through the synchroniser and history stage
  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    hist_d = sync_q;
  end

  // Synchroniser and edge-history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign rise = sync_q & ~hist_q;
  assign fall = ~sync_q & hist_q;

endmodule
`default_nettype wire

// File: rtl/link_serial_xfer.sv
`default_nettype none
// ============================================================================
// Module   : link_serial_xfer
// Brief    : Link-port serial shift engine (SB/SC). Internal clock at normal
//            or fast rate, or externally clocked with synchronised pins.
//            Optional build macro LINK_TIMEOUT_EN adds an external-clock
//            inter-edge timeout.
// Revision : 1.0 - initial release
// ============================================================================
module link_serial_xfer
  import link_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DIV_NORMAL  = DIV_NORMAL_8M,
  parameter int DIV_FAST    = DIV_FAST_8M,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_sc,
  input  logic              sc_start_in,
  input  logic              sc_int_clk_in,
  input  logic              sc_fast_in,
  input  logic              wr_sb,
  input  logic [DATA_W-1:0] sb_in,
  input  logic              serial_clk_in,
  input  logic              serial_data_in,
  output logic              serial_clk_out,
  output logic              serial_data_out,
  output logic [DATA_W-1:0] sb,
  output logic              sc_start,
  output logic              sc_int_clock,
  output logic              sc_fast,
  output logic              busy,
  output logic              serial_irq,
  output logic              xfer_timeout
);

  localparam int DIV_W = (DIV_NORMAL > 0) ? $clog2(DIV_NORMAL + 1) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [DIV_W-1:0] c_div_normal = DIV_W'(DIV_NORMAL);
  localparam logic [DIV_W-1:0] c_div_fast   = DIV_W'(DIV_FAST);
  localparam logic [CNT_W-1:0] c_last_bit   = CNT_W'(DATA_W - 1);

  // Elaboration-time parameter sanity checks
  generate
    if (DIV_FAST > DIV_NORMAL) begin : g_bad_div
      $error("link_serial_xfer: DIV_FAST must not exceed DIV_NORMAL");
    end
    if (DATA_W < 2) begin : g_bad_width
      $error("link_serial_xfer: DATA_W must be at least 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("link_serial_xfer: TIMEOUT_CYC must be at least 1");
    end
  endgenerate

  link_state_e       state_q, state_d;
  logic [DATA_W-1:0] sb_q, sb_d;
  logic              start_q, start_d;
  logic              int_q, int_d;
  logic              fast_q, fast_d;
  logic              clk_out_q, clk_out_d;
  logic              data_out_q, data_out_d;
  logic              irq_q, irq_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              data_meta_q, data_meta_d;
  logic              data_sync_q, data_sync_d;

  logic              w_clk_rise;
  logic              w_clk_fall;
  logic              w_to_hit;
  logic [DIV_W-1:0]  w_div_max;
  logic [DATA_W-1:0] w_sb_src;

  link_in_sync u_clk_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (serial_clk_in),
    .rise     (w_clk_rise),
    .fall     (w_clk_fall)
  );

  // The rate select only changes on an SC write, which also restarts, so
  // it is effectively sampled at start.
  assign w_div_max = fast_q ? c_div_fast : c_div_normal;
  // SB writes land only while idle; a same-cycle start shifts the new value.
  assign w_sb_src  = (wr_sb && (state_q == ST_IDLE)) ? sb_in : sb_q;

  // Next-state and output computation for the transfer sequencer
  always_comb begin
    state_d     = state_q;
    sb_d        = sb_q;
    start_d     = start_q;
    int_d       = int_q;
    fast_d      = fast_q;
    clk_out_d   = clk_out_q;
    data_out_d  = data_out_q;
    irq_d       = 1'b0;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    data_meta_d = serial_data_in;
    data_sync_d = data_meta_q;

    case (state_q)
      ST_IDLE: begin
        sb_d = w_sb_src;
      end
      ST_INT_LO: begin
        if (div_q == w_div_max) begin
          div_d     = '0;
          clk_out_d = 1'b1;
          // Peer is clocked by us, so the raw pin is already stable here
          sb_d      = {sb_q[DATA_W-2:0], serial_data_in};
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = (bit_cnt_q == c_last_bit) ? ST_DONE : ST_INT_HI;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_INT_HI: begin
        if (div_q == w_div_max) begin
          div_d      = '0;
          clk_out_d  = 1'b0;
          data_out_d = sb_q[DATA_W-1];
          state_d    = ST_INT_LO;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_EXT_WAIT: begin
        if (w_clk_fall) begin
          data_out_d = sb_q[DATA_W-1];
        end
        if (w_clk_rise) begin
          sb_d      = {sb_q[DATA_W-2:0], data_sync_q};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == c_last_bit) begin
            state_d = ST_DONE;
          end
        end else if (w_to_hit) begin
          state_d = ST_IDLE;
          start_d = 1'b0;
          irq_d   = 1'b1;
        end
      end
      ST_DONE: begin
        irq_d   = 1'b1;
        start_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An SC write overrides whatever the sequencer was doing this cycle
    if (wr_sc) begin
      start_d   = sc_start_in;
      int_d     = sc_int_clk_in;
      fast_d    = sc_fast_in;
      irq_d     = 1'b0;
      div_d     = '0;
      bit_cnt_d = '0;
      clk_out_d = 1'b1;
      sb_d      = w_sb_src;
      if (!sc_start_in) begin
        state_d = ST_IDLE;
      end else if (sc_int_clk_in) begin
        state_d    = ST_INT_LO;
        clk_out_d  = 1'b0;
        data_out_d = w_sb_src[DATA_W-1];
      end else begin
        state_d = ST_EXT_WAIT;
      end
    end
  end

  // Sequencer, shift register and registered pin outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sb_q        <= '0;
      start_q     <= 1'b0;
      int_q       <= 1'b0;
      fast_q      <= 1'b0;
      clk_out_q   <= 1'b1;
      data_out_q  <= 1'b1;
      irq_q       <= 1'b0;
      div_q       <= '0;
      bit_cnt_q   <= '0;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      sb_q        <= sb_d;
      start_q     <= start_d;
      int_q       <= int_d;
      fast_q      <= fast_d;
      clk_out_q   <= clk_out_d;
      data_out_q  <= data_out_d;
      irq_q       <= irq_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
    end
  end

`ifdef LINK_TIMEOUT_EN
  // Counter holds 0..TIMEOUT_CYC-1; the pulse registers as it would reach
  // TIMEOUT_CYC, i.e. TIMEOUT_CYC cycles after the last acted-on edge.
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;
  logic            w_to_armed;

  // Armed only in external mode once at least one bit has arrived
  assign w_to_armed = (state_q == ST_EXT_WAIT) && (bit_cnt_q != '0) &&
                      !w_clk_rise && !w_clk_fall && !wr_sc;
  assign w_to_hit   = w_to_armed && (to_cnt_q == c_to_last);

  // Inter-edge counter: clears on any edge or when not armed
  always_comb begin
    to_cnt_d  = '0;
    timeout_d = w_to_hit;
    if (w_to_armed && !w_to_hit) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // Timeout counter and pulse register
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign xfer_timeout = timeout_q;
`else
  assign w_to_hit     = 1'b0;
  assign xfer_timeout = 1'b0;
`endif

  assign serial_clk_out  = clk_out_q;
  assign serial_data_out = data_out_q;
  assign sb              = sb_q;
  assign sc_start        = start_q;
  assign sc_int_clock    = int_q;
  assign sc_fast         = fast_q;
  assign busy            = start_q;
  assign serial_irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_link_serial_xfer.sv
`default_nettype none
// ============================================================================
// Module   : tb_link_serial_xfer
// Brief    : Directed self-checking bench: 8-bit internal normal/fast,
//            32-bit external, abort, restart, mid-transfer reset, timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_link_serial_xfer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       a_wr_sc, a_start, a_int, a_fast, a_wr_sb, a_clk_in, a_data_in;
  logic [7:0] a_sb_in, a_sb;
  logic       a_clk_out, a_data_out, a_sc_start, a_sc_int, a_sc_fast;
  logic       a_busy, a_irq, a_to;

  // 32-bit instance
  logic        b_wr_sc, b_start, b_int, b_fast, b_wr_sb, b_clk_in, b_data_in;
  logic [31:0] b_sb_in, b_sb;
  logic        b_clk_out, b_data_out, b_sc_start, b_sc_int, b_sc_fast;
  logic        b_busy, b_irq, b_to;

  int n_tests = 0;
  int n_fail  = 0;

  link_serial_xfer #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .wr_sc(a_wr_sc), .sc_start_in(a_start),
    .sc_int_clk_in(a_int), .sc_fast_in(a_fast), .wr_sb(a_wr_sb), .sb_in(a_sb_in),
    .serial_clk_in(a_clk_in), .serial_data_in(a_data_in),
    .serial_clk_out(a_clk_out), .serial_data_out(a_data_out), .sb(a_sb),
    .sc_start(a_sc_start), .sc_int_clock(a_sc_int), .sc_fast(a_sc_fast),
    .busy(a_busy), .serial_irq(a_irq), .xfer_timeout(a_to)
  );

  link_serial_xfer #(.DATA_W(32), .TIMEOUT_CYC(100)) dut32 (
    .clk(clk), .rst(rst), .wr_sc(b_wr_sc), .sc_start_in(b_start),
    .sc_int_clk_in(b_int), .sc_fast_in(b_fast), .wr_sb(b_wr_sb), .sb_in(b_sb_in),
    .serial_clk_in(b_clk_in), .serial_data_in(b_data_in),
    .serial_clk_out(b_clk_out), .serial_data_out(b_data_out), .sb(b_sb),
    .sc_start(b_sc_start), .sc_int_clock(b_sc_int), .sc_fast(b_sc_fast),
    .busy(b_busy), .serial_irq(b_irq), .xfer_timeout(b_to)
  );

  // 8-bit instance: one-cycle SB write
  task automatic a_load_sb(input logic [7:0] v);
    a_sb_in = v; a_wr_sb = 1'b1;
    @(negedge clk);
    a_wr_sb = 1'b0;
  endtask

  // 8-bit instance: one-cycle SC write; returns at cycle 1
  task automatic a_write_sc(input logic st, input logic ic, input logic fs);
    a_start = st; a_int = ic; a_fast = fs; a_wr_sc = 1'b1;
    @(negedge clk);
    a_wr_sc = 1'b0; a_start = 1'b0;
  endtask

  task automatic b_load_sb(input logic [31:0] v);
    b_sb_in = v; b_wr_sb = 1'b1;
    @(negedge clk);
    b_wr_sb = 1'b0;
  endtask

  task automatic b_write_sc(input logic st, input logic ic, input logic fs);
    b_start = st; b_int = ic; b_fast = fs; b_wr_sc = 1'b1;
    @(negedge clk);
    b_wr_sc = 1'b0; b_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_tests++; if (a_sb !== 8'h00) begin n_fail++; $display("FAIL reset_sb: got %h expected 00", a_sb); end
    n_tests++; if (a_sc_start !== 1'b0) begin n_fail++; $display("FAIL reset_sc_start: got %b expected 0", a_sc_start); end
    n_tests++; if (a_sc_int !== 1'b0 || a_sc_fast !== 1'b0) begin n_fail++; $display("FAIL reset_sc_bits: got int=%b fast=%b expected 0 0", a_sc_int, a_sc_fast); end
    n_tests++; if (a_clk_out !== 1'b1 || a_data_out !== 1'b1) begin n_fail++; $display("FAIL reset_pins: got clk=%b data=%b expected 1 1", a_clk_out, a_data_out); end
    n_tests++; if (a_irq !== 1'b0 || a_to !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got irq=%b to=%b busy=%b expected 0 0 0", a_irq, a_to, a_busy); end
    n_tests++; if (b_sb !== 32'h0 || b_clk_out !== 1'b1 || b_data_out !== 1'b1) begin n_fail++; $display("FAIL reset_b: got sb=%h clk=%b data=%b expected 0 1 1", b_sb, b_clk_out, b_data_out); end
  endtask

  // 8-bit internal transfer of 0xA5 with data_in held high
  task automatic test_internal(input logic fs, input int irq_cyc, input int period);
    logic [7:0] pat;
    logic       prev;
    int         nbits, irq_cnt, irq_at, rise1, rise2;
    pat = 8'hA5; nbits = 0; irq_cnt = 0; irq_at = -1; rise1 = -1; rise2 = -1;
    a_load_sb(8'hA5);
    a_data_in = 1'b1;
    a_write_sc(1'b1, 1'b1, fs);
    n_tests++; if (a_clk_out !== 1'b0 || a_busy !== 1'b1) begin n_fail++; $display("FAIL int_cycle1: got clk=%b busy=%b expected 0 1", a_clk_out, a_busy); end
    n_tests++; if (a_sc_fast !== fs || a_sc_int !== 1'b1) begin n_fail++; $display("FAIL int_sc_readback: got fast=%b int=%b expected %b 1", a_sc_fast, a_sc_int, fs); end
    prev = a_clk_out;
    for (int k = 2; k <= irq_cyc + 20; k++) begin
      @(negedge clk);
      if (a_clk_out === 1'b1 && prev === 1'b0) begin
        if (rise1 < 0) rise1 = k; else if (rise2 < 0) rise2 = k;
        n_tests++;
        if (nbits > 7) begin
          n_fail++; $display("FAIL int_extra_rise: got rise %0d at cycle %0d expected 8 rises", nbits + 1, k);
        end else if (a_data_out !== pat[7 - nbits]) begin
          n_fail++; $display("FAIL int_data_bit%0d: got %b expected %b", nbits, a_data_out, pat[7 - nbits]);
        end
        nbits++;
      end
      prev = a_clk_out;
      if (a_irq === 1'b1) begin
        irq_cnt++; irq_at = k;
        n_tests++; if (a_sc_start !== 1'b0) begin n_fail++; $display("FAIL int_start_at_irq: got %b expected 0", a_sc_start); end
      end
    end
    n_tests++; if (nbits != 8) begin n_fail++; $display("FAIL int_rise_count: got %0d expected 8", nbits); end
    n_tests++; if (irq_cnt != 1 || irq_at != irq_cyc) begin n_fail++; $display("FAIL int_irq_cycle: got count=%0d at=%0d expected 1 at %0d", irq_cnt, irq_at, irq_cyc); end
    n_tests++; if (a_sb !== 8'hFF) begin n_fail++; $display("FAIL int_sb: got %h expected ff", a_sb); end
    n_tests++; if (rise2 - rise1 != period) begin n_fail++; $display("FAIL int_period: got %0d expected %0d", rise2 - rise1, period); end
  endtask

  // 32-bit external transfer: shift in 0x12345678, shift out 0xCAFEBABE
  task automatic test_ext32();
    logic [31:0] pat, prior, outw;
    int          irq_early, irq_at;
    pat = 32'h12345678; prior = 32'hCAFEBABE; outw = '0; irq_early = 0; irq_at = -1;
    b_clk_in = 1'b1;
    b_load_sb(prior);
    b_write_sc(1'b1, 1'b0, 1'b0);
    n_tests++; if (b_busy !== 1'b1 || b_clk_out !== 1'b1) begin n_fail++; $display("FAIL ext_start: got busy=%b clk_out=%b expected 1 1", b_busy, b_clk_out); end
    for (int i = 0; i < 32; i++) begin
      b_clk_in = 1'b0; b_data_in = pat[31 - i];
      repeat (8) @(negedge clk);
      outw = {outw[30:0], b_data_out};
      b_clk_in = 1'b1;
      if (i < 31) begin
        repeat (8) begin
          @(negedge clk);
          if (b_irq === 1'b1) irq_early++;
        end
      end else begin
        for (int k = 1; k <= 12; k++) begin
          @(negedge clk);
          if (b_irq === 1'b1 && irq_at < 0) irq_at = k;
        end
      end
    end
    n_tests++; if (outw !== prior) begin n_fail++; $display("FAIL ext_out_bits: got %h expected %h", outw, prior); end
    n_tests++; if (b_sb !== pat) begin n_fail++; $display("FAIL ext_sb: got %h expected %h", b_sb, pat); end
    n_tests++; if (irq_early != 0 || irq_at != 4) begin n_fail++; $display("FAIL ext_irq: got early=%0d at=%0d expected 0 at 4", irq_early, irq_at); end
    n_tests++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL ext_busy_end: got %b expected 0", b_busy); end
  endtask

  task automatic test_abort();
    logic [7:0] sb_snap;
    int         irq_cnt, clk_lo;
    irq_cnt = 0; clk_lo = 0;
    a_load_sb(8'h3C);
    a_write_sc(1'b1, 1'b1, 1'b1);
    repeat (50) @(negedge clk);
    a_write_sc(1'b0, 1'b1, 1'b1);
    n_tests++; if (a_clk_out !== 1'b1 || a_busy !== 1'b0) begin n_fail++; $display("FAIL abort_now: got clk=%b busy=%b expected 1 0", a_clk_out, a_busy); end
    sb_snap = a_sb;
    repeat (300) begin
      @(negedge clk);
      if (a_irq === 1'b1) irq_cnt++;
      if (a_clk_out !== 1'b1) clk_lo++;
    end
    n_tests++; if (irq_cnt != 0) begin n_fail++; $display("FAIL abort_irq: got %0d pulses expected 0", irq_cnt); end
    n_tests++; if (clk_lo != 0) begin n_fail++; $display("FAIL abort_clk_out: got %0d low cycles expected 0", clk_lo); end
    n_tests++; if (a_sb !== sb_snap) begin n_fail++; $display("FAIL abort_sb_hold: got %h expected %h", a_sb, sb_snap); end
  endtask

  task automatic test_restart();
    int irq_cnt, irq_at;
    irq_cnt = 0; irq_at = -1;
    a_load_sb(8'h3C);
    a_data_in = 1'b0;
    a_write_sc(1'b1, 1'b1, 1'b1);
    repeat (100) begin
      @(negedge clk);
      if (a_irq === 1'b1) irq_cnt++;
    end
    a_write_sc(1'b1, 1'b1, 1'b1);
    for (int k = 2; k <= 300; k++) begin
      @(negedge clk);
      if (a_irq === 1'b1) begin irq_cnt++; irq_at = k; end
    end
    n_tests++; if (irq_cnt != 1 || irq_at != 242) begin n_fail++; $display("FAIL restart_irq: got count=%0d at=%0d expected 1 at 242", irq_cnt, irq_at); end
    n_tests++; if (a_sb !== 8'h00) begin n_fail++; $display("FAIL restart_sb: got %h expected 00", a_sb); end
  endtask

  task automatic test_rst_mid();
    int irq_cnt;
    irq_cnt = 0;
    a_load_sb(8'h5A);
    a_data_in = 1'b1;
    a_write_sc(1'b1, 1'b1, 1'b1);
    repeat (90) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (a_sb !== 8'h00) begin n_fail++; $display("FAIL rst_mid_sb: got %h expected 00", a_sb); end
    n_tests++; if (a_sc_start !== 1'b0 || a_sc_int !== 1'b0 || a_sc_fast !== 1'b0) begin n_fail++; $display("FAIL rst_mid_sc: got %b%b%b expected 000", a_sc_start, a_sc_int, a_sc_fast); end
    n_tests++; if (a_clk_out !== 1'b1 || a_data_out !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pins: got clk=%b data=%b expected 1 1", a_clk_out, a_data_out); end
    n_tests++; if (a_irq !== 1'b0 || a_to !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags: got irq=%b to=%b expected 0 0", a_irq, a_to); end
    repeat (300) begin
      @(negedge clk);
      if (a_irq === 1'b1) irq_cnt++;
    end
    n_tests++; if (irq_cnt != 0) begin n_fail++; $display("FAIL rst_mid_irq: got %0d pulses expected 0", irq_cnt); end
  endtask

  // 32-bit external: three bits 1,0,1 then the clock stays high
  task automatic test_timeout();
    int to_cnt, irq_cnt, to_at, both;
    to_cnt = 0; irq_cnt = 0; to_at = -1; both = 0;
    b_clk_in = 1'b1;
    b_load_sb(32'h0);
    b_write_sc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      b_clk_in = 1'b0; b_data_in = (i != 1);
      repeat (8) @(negedge clk);
      b_clk_in = 1'b1;
      if (i < 2) repeat (8) @(negedge clk);
    end
`ifdef LINK_TIMEOUT_EN
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (b_to === 1'b1) begin to_cnt++; if (to_at < 0) to_at = k; if (b_irq === 1'b1) both++; end
      if (b_irq === 1'b1) irq_cnt++;
    end
    n_tests++; if (to_cnt != 1 || to_at != 103) begin n_fail++; $display("FAIL timeout_pulse: got count=%0d at=%0d expected 1 at 103", to_cnt, to_at); end
    n_tests++; if (irq_cnt != 1 || both != 1) begin n_fail++; $display("FAIL timeout_irq: got irq=%0d with_to=%0d expected 1 1", irq_cnt, both); end
    n_tests++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b expected 0", b_busy); end
    n_tests++; if (b_sb !== 32'h5) begin n_fail++; $display("FAIL timeout_sb: got %h expected 00000005", b_sb); end
`else
    repeat (10000) begin
      @(negedge clk);
      if (b_to === 1'b1) to_cnt++;
      if (b_irq === 1'b1) irq_cnt++;
    end
    n_tests++; if (to_cnt != 0 || irq_cnt != 0) begin n_fail++; $display("FAIL no_timeout: got to=%0d irq=%0d expected 0 0", to_cnt, irq_cnt); end
    n_tests++; if (b_busy !== 1'b1) begin n_fail++; $display("FAIL no_timeout_busy: got %b expected 1", b_busy); end
    n_tests++; if (b_sb !== 32'h5) begin n_fail++; $display("FAIL no_timeout_sb: got %h expected 00000005", b_sb); end
    b_write_sc(1'b0, 1'b0, 1'b0);
    n_tests++; if (b_busy !== 1'b0 || b_irq !== 1'b0) begin n_fail++; $display("FAIL no_timeout_abort: got busy=%b irq=%b expected 0 0", b_busy, b_irq); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    a_wr_sc = 0; a_start = 0; a_int = 0; a_fast = 0; a_wr_sb = 0; a_sb_in = '0; a_clk_in = 1; a_data_in = 1;
    b_wr_sc = 0; b_start = 0; b_int = 0; b_fast = 0; b_wr_sb = 0; b_sb_in = '0; b_clk_in = 1; b_data_in = 1;
    @(negedge clk);
    test_reset();
    test_internal(1'b0, 7682, 1024);
    test_internal(1'b1, 242, 32);
    test_ext32();
    test_abort();
    test_restart();
    test_rst_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
